carregador_programa: RTL and testbench

Serial program loader that sits directly upstream of the 8-bit processor's instruction memory. It receives a program image over a UART line (8N1), writes each byte into instruction memory through a write port, and verifies a checksum. It holds the processor in reset while loading and releases it only after a verified image, so the core always starts at PC = 0 on a complete program.

---
 rtl/carregador_programa.sv | 174 +++++++++++++++++
 tb/tb_carregador_programa.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/carregador_programa.sv
// UART (8N1) program loader: writes LEN-framed image into instruction memory,
// verifies an 8-bit additive checksum and holds the CPU in reset until verified.
module carregador_programa #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       prog_we,
  output logic [7:0] prog_addr,
  output logic [7:0] prog_data,
  output logic       cpu_reset,
  output logic       loading,
  output logic       done,
  output logic       erro
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HI} rx_state_t;
  typedef enum logic [1:0] {L_IDLE, L_PAYLOAD, L_CHECKSUM, L_RUN} ld_state_t;

  rx_state_t rx_st, rx_nx;
  ld_state_t ld_st, ld_nx;

  logic          rx_s1, rx_sync;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_byte;
  logic          cnt_clr, shift_en, byte_valid, frame_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_sync <= 1'b1;
      rx_st   <= RX_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      rx_byte <= '0;
    end else begin
      rx_s1   <= rx;
      rx_sync <= rx_s1;
      rx_st   <= rx_nx;
      clk_cnt <= cnt_clr ? '0 : clk_cnt + 1'b1;
      if (rx_st == RX_START) bit_idx <= '0;
      else if (shift_en)     bit_idx <= bit_idx + 3'd1;
      if (shift_en) rx_byte <= {rx_sync, rx_byte[7:1]};
    end
  end

  // Idle is level-triggered: it is only entered with the line high, so a low
  // level there is always a fresh falling edge.
  always_comb begin
    rx_nx      = rx_st;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_st)
      RX_IDLE: if (!rx_sync) begin
        rx_nx   = RX_START;
        cnt_clr = 1'b1;
      end
      RX_START: if (clk_cnt == HALF) begin
        cnt_clr = 1'b1;
        rx_nx   = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (clk_cnt == FULL) begin
        cnt_clr  = 1'b1;
        shift_en = 1'b1;
        if (bit_idx == 3'd7) rx_nx = RX_STOP;
      end
      RX_STOP: if (clk_cnt == FULL) begin
        cnt_clr = 1'b1;
        if (rx_sync) begin
          byte_valid = 1'b1;
          rx_nx      = RX_IDLE;
        end else begin
          frame_err = 1'b1;
          rx_nx     = RX_WAIT_HI;
        end
      end
      RX_WAIT_HI: if (rx_sync) rx_nx = RX_IDLE;
      default: rx_nx = RX_IDLE;
    endcase
  end

  logic [8:0] n_len, n_len_nx, cnt, cnt_nx;
  logic [7:0] sum, sum_nx, addr_nx, data_nx;
  logic       we_nx, cpu_reset_nx, loading_nx, done_nx, erro_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_st     <= L_IDLE;
      n_len     <= '0;
      cnt       <= '0;
      sum       <= '0;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      cpu_reset <= 1'b1;
      loading   <= 1'b0;
      done      <= 1'b0;
      erro      <= 1'b0;
    end else begin
      ld_st     <= ld_nx;
      n_len     <= n_len_nx;
      cnt       <= cnt_nx;
      sum       <= sum_nx;
      prog_we   <= we_nx;
      prog_addr <= addr_nx;
      prog_data <= data_nx;
      cpu_reset <= cpu_reset_nx;
      loading   <= loading_nx;
      done      <= done_nx;
      erro      <= erro_nx;
    end
  end

  always_comb begin
    ld_nx        = ld_st;
    n_len_nx     = n_len;
    cnt_nx       = cnt;
    sum_nx       = sum;
    we_nx        = 1'b0;
    addr_nx      = prog_addr;
    data_nx      = prog_data;
    cpu_reset_nx = cpu_reset;
    loading_nx   = loading;
    done_nx      = done;
    erro_nx      = erro;
    if (frame_err) begin
      ld_nx        = L_IDLE;
      loading_nx   = 1'b0;
      erro_nx      = 1'b1;
      cpu_reset_nx = 1'b1;
      done_nx      = 1'b0;
    end else if (byte_valid) begin
      case (ld_st)
        L_IDLE, L_RUN: begin
          n_len_nx     = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
          sum_nx       = '0;
          cnt_nx       = '0;
          loading_nx   = 1'b1;
          cpu_reset_nx = 1'b1;
          done_nx      = 1'b0;
          erro_nx      = 1'b0;
          ld_nx        = L_PAYLOAD;
        end
        L_PAYLOAD: begin
          we_nx   = 1'b1;
          addr_nx = cnt[7:0];
          data_nx = rx_byte;
          sum_nx  = sum + rx_byte;
          cnt_nx  = cnt + 9'd1;
          if (cnt + 9'd1 == n_len) ld_nx = L_CHECKSUM;
        end
        L_CHECKSUM: begin
          loading_nx = 1'b0;
          if (rx_byte == sum) begin
            done_nx      = 1'b1;
            cpu_reset_nx = 1'b0;
            ld_nx        = L_RUN;
          end else begin
            erro_nx = 1'b1;
            ld_nx   = L_IDLE;
          end
        end
        default: ld_nx = L_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_carregador_programa.sv
// Scoreboarded bench for carregador_programa: expected memory writes are
// queued as bytes are sent and checked whenever prog_we pulses.
module tb_carregador_programa;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       prog_we, cpu_reset, loading, done, erro;
  logic [7:0] prog_addr, prog_data;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int n_writes = 0;
  logic [15:0] exp_q[$];

  carregador_programa #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .cpu_reset(cpu_reset), .loading(loading), .done(done),
    .erro(erro)
  );

  always #5 clk = ~clk;

  // Scoreboard: every write strobe must match the oldest queued {addr,data}.
  always @(negedge clk) begin
    if (!reset && prog_we) begin
      logic [15:0] exp_w;
      n_writes++;
      cmp_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL unexpected_write: addr=%h data=%h, required no write", prog_addr, prog_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({prog_addr, prog_data} !== exp_w) begin
          err_cnt++;
          $display("FAIL write: addr/data=%h/%h, required %h/%h",
                   prog_addr, prog_data, exp_w[15:8], exp_w[7:0]);
        end
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic check_status(input string name, input logic e_cr, input logic e_ld,
                              input logic e_dn, input logic e_er);
    cmp_cnt++;
    if ({cpu_reset, loading, done, erro} !== {e_cr, e_ld, e_dn, e_er}) begin
      err_cnt++;
      $display("FAIL %s: cpu_reset/loading/done/erro=%b%b%b%b, required %b%b%b%b",
               name, cpu_reset, loading, done, erro, e_cr, e_ld, e_dn, e_er);
    end
  endtask

  task automatic check_drained(input string name, input int exp_writes);
    cmp_cnt++;
    if (exp_q.size() != 0 || n_writes != exp_writes) begin
      err_cnt++;
      $display("FAIL %s: writes=%0d pending=%0d, required writes=%0d pending=0",
               name, n_writes, exp_q.size(), exp_writes);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if ({prog_we, prog_addr, prog_data, cpu_reset, loading, done, erro} !== {1'b0, 16'h0, 4'b1000}) begin
      err_cnt++;
      $display("FAIL reset_values: we=%b addr=%h data=%h cr=%b ld=%b dn=%b er=%b, required 0 00 00 1 0 0 0",
               prog_we, prog_addr, prog_data, cpu_reset, loading, done, erro);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Sends LEN, payload, CHK back to back; queues the writes the payload implies.
  task automatic send_frame(input logic [7:0] len, input logic [7:0] pay[$], input logic [7:0] chk);
    send_byte(len);
    for (int i = 0; i < pay.size(); i++) begin
      exp_q.push_back({8'(i), pay[i]});
      send_byte(pay[i]);
    end
    send_byte(chk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    n_writes = 0;
    send_frame(8'h03, '{8'h12, 8'h34, 8'h56}, 8'h9C);
    check_drained("basic_writes", 3);
    check_status("basic_status", 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_bad_checksum();
    n_writes = 0;
    send_frame(8'h02, '{8'hAA, 8'h01}, 8'h00);
    check_drained("badchk_writes", 2);
    check_status("badchk_status", 1'b1, 1'b0, 1'b0, 1'b1);
    n_writes = 0;
    send_byte(8'h01);
    repeat (2) @(negedge clk);
    check_status("badchk_len_clears_erro", 1'b1, 1'b1, 1'b0, 1'b0);
    exp_q.push_back({8'h00, 8'h55});
    send_byte(8'h55);
    send_byte(8'h55);
    repeat (3) @(negedge clk);
    check_drained("badchk_recover_writes", 1);
    check_status("badchk_recover_status", 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_full_image();
    logic [7:0] pay[$];
    for (int i = 0; i < 256; i++) pay.push_back(8'(i));
    n_writes = 0;
    send_frame(8'h00, pay, 8'h80);
    check_drained("full_writes", 256);
    cmp_cnt++;
    if (prog_addr !== 8'hFF || prog_data !== 8'hFF) begin
      err_cnt++;
      $display("FAIL full_last_addr: addr=%h data=%h, required FF FF", prog_addr, prog_data);
    end
    check_status("full_status", 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_framing_error();
    n_writes = 0;
    send_byte(8'h02);
    exp_q.push_back({8'h00, 8'h11});
    send_byte(8'h11);
    send_byte(8'h22, 1'b0);
    repeat (3) @(negedge clk);
    check_drained("framing_no_write", 1);
    check_status("framing_status", 1'b1, 1'b0, 1'b0, 1'b1);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_status("framing_hold", 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reload();
    n_writes = 0;
    send_frame(8'h01, '{8'h33}, 8'h33);
    check_status("reload_first", 1'b0, 1'b0, 1'b1, 1'b0);
    send_byte(8'h01);
    repeat (2) @(negedge clk);
    check_status("reload_len", 1'b1, 1'b1, 1'b0, 1'b0);
    exp_q.push_back({8'h00, 8'h7E});
    send_byte(8'h7E);
    send_byte(8'h7E);
    repeat (3) @(negedge clk);
    check_drained("reload_writes", 2);
    check_status("reload_status", 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_glitch();
    n_writes = 0;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check_drained("glitch_no_write", 0);
    check_status("glitch_status", 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midload();
    n_writes = 0;
    send_byte(8'h04);
    exp_q.push_back({8'h00, 8'hC1});
    send_byte(8'hC1);
    exp_q.push_back({8'h01, 8'hC2});
    send_byte(8'hC2);
    repeat (2) @(negedge clk);
    check_drained("midload_pre_writes", 2);
    reset = 1'b1;
    #1;
    cmp_cnt++;
    if ({prog_we, prog_addr, prog_data, cpu_reset, loading, done, erro} !== {1'b0, 16'h0, 4'b1000}) begin
      err_cnt++;
      $display("FAIL midload_async_reset: we=%b addr=%h data=%h cr=%b ld=%b dn=%b er=%b, required 0 00 00 1 0 0 0",
               prog_we, prog_addr, prog_data, cpu_reset, loading, done, erro);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_writes = 0;
    send_frame(8'h02, '{8'hD4, 8'h05}, 8'hD9);
    check_drained("midload_reload_writes", 2);
    check_status("midload_reload_status", 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_bad_checksum();
    test_full_image();
    test_framing_error();
    test_reload();
    test_glitch();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
